// File: rtl/padlock_pkg.sv
// Shared types and constants for the keypad padlock controller.
package padlock_pkg;

    localparam int unsigned DIGIT_W    = 2;
    localparam int unsigned NUM_DIGITS = 1 << DIGIT_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Default code 2,1,3,0 with digit k at bits [2k+1:2k].
    localparam logic [7:0] DEFAULT_CODE = 8'h36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_e;

endpackage

// File: rtl/padlock_edge.sv
// Rising-edge detector: one-cycle pulse when a level goes from 0 to 1.
module padlock_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= '0;
        else        prev_q <= din;
    end

    assign rise_c = din & ~prev_q;

endmodule

// File: rtl/padlock_ctrl.sv
// Keypad padlock sequencer: digit entry, code check, lockout and relock timing.
module padlock_ctrl
    import padlock_pkg::*;
#(
    parameter int unsigned             CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] CODE       = DEFAULT_CODE,
    parameter int unsigned             MAX_FAILS      = 3,
    parameter int unsigned             LOCKOUT_CYCLES = 1000,
    parameter int unsigned             ENTRY_TIMEOUT  = 2000,
    parameter int unsigned             RELOCK_CYCLES  = 5000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_DIGITS-1:0]            but,
    input  logic                             open,
    input  logic                             relock,
    output logic                             lock,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [$clog2(CODE_LEN+1)-1:0]    entry_count
);

    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned ENTRY_W = $clog2(CODE_LEN + 1);
    localparam int unsigned IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned MAX_T0  = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
    localparam int unsigned MAX_T   = (MAX_T0 > RELOCK_CYCLES) ? MAX_T0 : RELOCK_CYCLES;
    localparam int unsigned TIMER_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    logic [NUM_DIGITS-1:0] but_rise;
    logic                  open_ev;
    logic                  relock_ev;

    padlock_edge #(.W(NUM_DIGITS)) u_but_edge (
        .clk(clk), .reset(reset), .din(but), .rise_c(but_rise)
    );
    padlock_edge #(.W(1)) u_open_edge (
        .clk(clk), .reset(reset), .din(open), .rise_c(open_ev)
    );
    padlock_edge #(.W(1)) u_relock_edge (
        .clk(clk), .reset(reset), .din(relock), .rise_c(relock_ev)
    );

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 lock_d, locked_out_d;
    logic [FAIL_W-1:0]    fail_d;
    logic [ENTRY_W-1:0]   entry_d;
    digit_t               buf_q [CODE_LEN];
    logic                 buf_we;
    logic [IDX_W-1:0]     buf_idx;
    logic                 timer_clr;
    logic                 dig_valid;
    digit_t               dig_val;
    logic                 match;

    // Lowest-index button rise wins.
    always_comb begin
        dig_valid = 1'b0;
        dig_val   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (but_rise[k]) begin
                dig_valid = 1'b1;
                dig_val   = DIGIT_W'(k);
            end
        end
    end

    always_comb begin
        match = (entry_count == ENTRY_W'(CODE_LEN));
        for (int k = 0; k < CODE_LEN; k++) begin
            if (buf_q[k] != CODE[DIGIT_W*k +: DIGIT_W]) match = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_d       = lock;
        locked_out_d = locked_out;
        fail_d       = fail_count;
        entry_d      = entry_count;
        buf_we       = 1'b0;
        buf_idx      = IDX_W'(entry_count);
        timer_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (open_ev) begin
                    state_d = ST_CHECK;
                end else if (dig_valid) begin
                    buf_we  = 1'b1;
                    buf_idx = '0;
                    entry_d = ENTRY_W'(1);
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (open_ev) begin
                    state_d = ST_CHECK;
                end else if (dig_valid && entry_count < ENTRY_W'(CODE_LEN)) begin
                    buf_we    = 1'b1;
                    entry_d   = ENTRY_W'(entry_count + 1'b1);
                    timer_clr = 1'b1;
                end else if (timer_q == TIMER_W'(ENTRY_TIMEOUT - 1)) begin
                    entry_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                entry_d = '0;
                if (match) begin
                    lock_d  = 1'b0;
                    fail_d  = '0;
                    state_d = ST_UNLOCKED;
                end else begin
                    fail_d = FAIL_W'(fail_count + 1'b1);
                    if (fail_d == FAIL_W'(MAX_FAILS)) begin
                        locked_out_d = 1'b1;
                        state_d      = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock_ev || timer_q == TIMER_W'(RELOCK_CYCLES - 1)) begin
                    lock_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == TIMER_W'(LOCKOUT_CYCLES - 1)) begin
                    locked_out_d = 1'b0;
                    fail_d       = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared saturating timer, restarted on any state change.
        if (state_d != state_q || timer_clr) timer_d = '0;
        else if (timer_q != '1)               timer_d = timer_q + 1'b1;
        else                                  timer_d = timer_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            lock        <= 1'b1;
            locked_out  <= 1'b0;
            fail_count  <= '0;
            entry_count <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lock        <= lock_d;
            locked_out  <= locked_out_d;
            fail_count  <= fail_d;
            entry_count <= entry_d;
        end
    end

    // Entry buffer holds don't-care data after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_idx] <= dig_val;
    end

endmodule

// File: doc/padlock_ctrl.md
Name: padlock_ctrl

Overview:
- Sequencing controller for the keypad padlock: turns raw button levels into one-shot digit entries and collects them into an entry buffer.
- Checks the collected code on an open request and drives the lock output.
- Enforces a failed-attempt lockout, an entry inactivity timeout and an auto-relock timer.
- Sits between the synchronised front-panel inputs and the lock actuator. Replaces ad-hoc "store on level, compare on open" logic.

Parameters:
- CODE_LEN, 4: number of 2-bit digits in a code (1..8).
- CODE, 8'h36: expected code; digit k at bits [2k+1:2k] (8'h36 = 2,1,3,0); width 2*CODE_LEN.
- MAX_FAILS, 3: consecutive wrong checks that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles.
- ENTRY_TIMEOUT, 2000: idle cycles in ENTRY before the partial entry is discarded.
- RELOCK_CYCLES, 5000: cycles in UNLOCKED before automatic relock.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- but  in  4  button levels, synchronous to clk; bit k = digit k.
- open  in  1  open-request level.
- relock  in  1  manual relock request level.
- lock  out  1  1 = locked.
- locked_out  out  1  1 while in LOCKOUT.
- fail_count  out  clog2(MAX_FAILS+1)  consecutive failed checks.
- entry_count  out  clog2(CODE_LEN+1)  digits currently held.

Behaviour:
- Reset (reset=0, async):
  - State IDLE, lock=1, locked_out=0, fail_count=0, entry_count=0.
  - Timers 0; edge-detect history regs = 0.
  - Entry buffer contents don't-care.
  - Reset mid-operation aborts everything, including LOCKOUT.
- Edge detect: registered copies of but/open/relock. An event is input=1 and previous=0. Held levels produce a single event.
- Digit priority: several button rises in one cycle → lowest index wins, the others are dropped.
- States: IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT.
- IDLE:
  - Digit event → store at slot 0, entry_count=1, go ENTRY.
  - Open event → CHECK (entry_count=0, so it counts as a failure).
- ENTRY:
  - Digit event with entry_count<CODE_LEN → store at slot entry_count, increment, clear the inactivity timer.
  - Digit event with entry_count==CODE_LEN → ignored (no overwrite, no wrap).
  - Open event → CHECK.
  - Inactivity timer reaching ENTRY_TIMEOUT → entry_count=0, go IDLE. No failure is counted.
- Open vs digit in the same cycle: open has priority and the digit is discarded.
- CHECK (exactly 1 cycle; all inputs ignored):
  - Match iff entry_count==CODE_LEN and every slot equals CODE.
  - Match → UNLOCKED, lock<=0, fail_count<=0.
  - Mismatch → fail_count+1. If the new value ==MAX_FAILS → LOCKOUT, locked_out<=1; otherwise → IDLE.
  - entry_count<=0 on both paths.
- Latency: open sampled high (first cycle) at edge N → CHECK after N → lock low after edge N+1. Buttons follow the same rule: entry_count updates after the sampling edge.
- UNLOCKED:
  - lock=0.
  - Relock event, or timer reaching RELOCK_CYCLES → IDLE, lock<=1.
  - Digit and open events are ignored.
- LOCKOUT:
  - Buttons, open and relock are ignored.
  - After LOCKOUT_CYCLES cycles → IDLE, locked_out<=0, fail_count<=0.
- Counters:
  - A single shared timer, cleared on every state change.
  - Saturating, width clog2 of the largest timeout parameter.
  - fail_count never exceeds MAX_FAILS.
- Outputs are registered, with no combinational path from inputs.

Decomposition:
- Shared package padlock_pkg:
  - State enum (IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT).
  - DIGIT_W=2 and the digit typedef.
  - Default CODE constant.
- One sub-module, padlock_edge: parameterised-width rising-edge detector with async active-low reset. Instantiated for but, open and relock.
- FSM, timer and entry buffer stay in padlock_ctrl.

Test Plan:
1. Release reset; press 2,1,3,0 (one-cycle pulses, gaps); pulse open at edge N → lock=1 after N, lock=0 after N+1, fail_count=0, entry_count=0.
2. Press 2,1,3,1 then open → lock stays 1, fail_count=1. Repeat twice → locked_out=1 and fail_count=3. Correct code + open during lockout → lock stays 1. After 1000 cycles locked_out=0, fail_count=0.
3. Hold but[2] high 10 cycles → entry_count=1. Rise but[0] and but[3] together → one digit 0 stored. Rise but[1] and open same cycle → digit dropped, check fails, fail_count=1.
4. Press 2,1 then wait 2000 cycles → entry_count=0, state IDLE, fail_count unchanged. Press 2,1,3,0,3 then open → 5th digit ignored, unlock.
5. Unlock, then wait 5000 cycles → lock=1. Unlock again, pulse relock after 10 cycles → lock=1 next edge.
6. Assert reset low asynchronously mid-ENTRY and mid-LOCKOUT → outputs immediately lock=1, locked_out=0, counts 0.
